// File: rtl/mont_const_stream.sv
// Montgomery constant generator: r = 2^KEY_W mod n, t = 2^(2*KEY_W) mod n, n0p = -n^-1 mod 2^WORD_W.
// r and t are streamed as WORD_W-bit word pairs over a valid/ready handshake.
module mont_const_stream #(
  parameter int KEY_W     = 1024,
  parameter int WORD_W    = 32,
  parameter int MSW_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  n,
  output logic              busy,
  output logic              err,
  output logic [WORD_W-1:0] n0p,
  output logic              n0p_valid,
  output logic [WORD_W-1:0] out_r,
  output logic [WORD_W-1:0] out_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
);

  // state    | meaning
  // S_IDLE   | waiting for start; bad moduli rejected here with an err pulse
  // S_CALC   | 2*KEY_W modular doublings, n0p inverse in the first WORD_W-1 cycles
  // S_LOAD   | publish n0p, present the first word pair
  // S_STREAM | hand out word pairs under valid/ready
  // S_FIN    | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_LOAD, S_STREAM, S_FIN} state_t;

  localparam int NW    = KEY_W / WORD_W;
  localparam int KW_W  = $clog2(NW) + 1;
  localparam int CNT_W = $clog2(2*KEY_W + 1);
  localparam logic [KW_W-1:0]  LAST_K  = KW_W'(NW - 1);
  localparam logic [CNT_W-1:0] CNT_R   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] CNT_T   = CNT_W'(2*KEY_W - 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(2*KEY_W);

  state_t state, state_nxt;

  logic [KEY_W-1:0]  n_reg, r_reg, t_reg, r_shift, t_shift;
  logic [KEY_W:0]    acc, acc_dbl, acc_nxt;
  logic [WORD_W-1:0] inv, bitm, prod, r_word, t_word;
  logic [CNT_W-1:0]  cnt;
  logic [KW_W-1:0]   k;
  logic              n_bad, xfer;

  assign n_bad   = ~n[0] | (n == KEY_W'(1));
  assign xfer    = out_valid & out_ready;
  assign acc_dbl = acc << 1;
  assign acc_nxt = (acc_dbl >= {1'b0, n_reg}) ? acc_dbl - {1'b0, n_reg} : acc_dbl;
  assign prod    = n_reg[WORD_W-1:0] * inv;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_FIN);

  // r_reg/t_reg double as shift registers during streaming, so only fixed slices are needed.
  generate
    if (MSW_FIRST != 0) begin : g_msw
      assign r_word  = r_reg[KEY_W-1 -: WORD_W];
      assign t_word  = t_reg[KEY_W-1 -: WORD_W];
      assign r_shift = r_reg << WORD_W;
      assign t_shift = t_reg << WORD_W;
    end else begin : g_lsw
      assign r_word  = r_reg[WORD_W-1:0];
      assign t_word  = t_reg[WORD_W-1:0];
      assign r_shift = r_reg >> WORD_W;
      assign t_shift = t_reg >> WORD_W;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !n_bad) state_nxt = S_CALC;
      S_CALC:   if (cnt == CNT_END) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_STREAM;
      S_STREAM: if (xfer && out_last) state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg     <= '0;
      r_reg     <= '0;
      t_reg     <= '0;
      acc       <= '0;
      inv       <= '0;
      bitm      <= '0;
      cnt       <= '0;
      k         <= '0;
      err       <= 1'b0;
      n0p       <= '0;
      n0p_valid <= 1'b0;
      out_r     <= '0;
      out_t     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (n_bad) begin
              err <= 1'b1;
            end else begin
              n_reg     <= n;
              acc       <= (KEY_W+1)'(1);
              inv       <= WORD_W'(1);
              bitm      <= WORD_W'(2);
              cnt       <= '0;
              n0p_valid <= 1'b0;
            end
          end
        end
        S_CALC: begin
          if (cnt != CNT_END) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_R) r_reg <= acc_nxt[KEY_W-1:0];
            if (cnt == CNT_T) t_reg <= acc_nxt[KEY_W-1:0];
            // bitm walks bit 1..WORD_W-1 and then falls off the top, ending the inverse
            if (bitm != '0) begin
              if (|(prod & bitm)) inv <= inv | bitm;
              bitm <= bitm << 1;
            end
          end
        end
        S_LOAD: begin
          n0p       <= -inv;
          n0p_valid <= 1'b1;
          out_valid <= 1'b1;
          out_r     <= r_word;
          out_t     <= t_word;
          r_reg     <= r_shift;
          t_reg     <= t_shift;
          k         <= '0;
          out_last  <= (LAST_K == '0);
        end
        S_STREAM: begin
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              k        <= k + KW_W'(1);
              out_r    <= r_word;
              out_t    <= t_word;
              r_reg    <= r_shift;
              t_reg    <= t_shift;
              out_last <= ((k + KW_W'(1)) == LAST_K);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_const_stream.sv
// Bench for mont_const_stream: two 16/8 instances (MSW and LSW first) share stimulus,
// plus a 1024/32 instance checked against an independent wide-arithmetic model.
module tb_mont_const_stream;

  typedef struct {
    logic [31:0] r;
    logic [31:0] t;
    logic        last;
  } word_t;

  logic clk, rst_n;

  logic        s_start, s_ready;
  logic [15:0] s_n;
  logic        a_busy, a_err, a_n0p_valid, a_valid, a_last, a_done;
  logic [7:0]  a_n0p, a_r, a_t;
  logic        b_busy, b_err, b_n0p_valid, b_valid, b_last, b_done;
  logic [7:0]  b_n0p, b_r, b_t;

  logic          g_start, g_ready;
  logic [1023:0] g_n;
  logic          g_busy, g_err, g_n0p_valid, g_valid, g_last, g_done;
  logic [31:0]   g_n0p, g_r, g_t;

  word_t q_a[$], q_b[$], q_g[$];
  word_t ea, eb, eg;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int xf_a = 0, xf_b = 0, xf_g = 0, err_a = 0, err_b = 0;
  int xcyc_a = 0, dcyc_a = 0, xcyc_g = 0, dcyc_g = 0;

  mont_const_stream #(.KEY_W(16), .WORD_W(8), .MSW_FIRST(1)) u_msw (
    .clk(clk), .rst_n(rst_n), .start(s_start), .n(s_n), .busy(a_busy), .err(a_err),
    .n0p(a_n0p), .n0p_valid(a_n0p_valid), .out_r(a_r), .out_t(a_t), .out_valid(a_valid),
    .out_ready(s_ready), .out_last(a_last), .done(a_done));

  mont_const_stream #(.KEY_W(16), .WORD_W(8), .MSW_FIRST(0)) u_lsw (
    .clk(clk), .rst_n(rst_n), .start(s_start), .n(s_n), .busy(b_busy), .err(b_err),
    .n0p(b_n0p), .n0p_valid(b_n0p_valid), .out_r(b_r), .out_t(b_t), .out_valid(b_valid),
    .out_ready(s_ready), .out_last(b_last), .done(b_done));

  mont_const_stream #(.KEY_W(1024), .WORD_W(32), .MSW_FIRST(1)) u_big (
    .clk(clk), .rst_n(rst_n), .start(g_start), .n(g_n), .busy(g_busy), .err(g_err),
    .n0p(g_n0p), .n0p_valid(g_n0p_valid), .out_r(g_r), .out_t(g_t), .out_valid(g_valid),
    .out_ready(g_ready), .out_last(g_last), .done(g_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare on every transfer, sampled half a cycle before the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_err) err_a++;
      if (b_err) err_b++;
      if (a_done) dcyc_a = cyc;
      if (g_done) dcyc_g = cyc;
      if (a_valid && s_ready) begin
        xf_a++; xcyc_a = cyc; n_cmp++;
        if (q_a.size() == 0) begin
          n_fail++; $display("FAIL msw_word: got r=%h t=%h last=%b, required no transfer", a_r, a_t, a_last);
        end else begin
          ea = q_a.pop_front();
          if ({24'b0, a_r} !== ea.r || {24'b0, a_t} !== ea.t || a_last !== ea.last) begin
            n_fail++;
            $display("FAIL msw_word: got r=%h t=%h last=%b, required r=%h t=%h last=%b", a_r, a_t, a_last, ea.r[7:0], ea.t[7:0], ea.last);
          end
        end
      end
      if (b_valid && s_ready) begin
        xf_b++; n_cmp++;
        if (q_b.size() == 0) begin
          n_fail++; $display("FAIL lsw_word: got r=%h t=%h last=%b, required no transfer", b_r, b_t, b_last);
        end else begin
          eb = q_b.pop_front();
          if ({24'b0, b_r} !== eb.r || {24'b0, b_t} !== eb.t || b_last !== eb.last) begin
            n_fail++;
            $display("FAIL lsw_word: got r=%h t=%h last=%b, required r=%h t=%h last=%b", b_r, b_t, b_last, eb.r[7:0], eb.t[7:0], eb.last);
          end
        end
      end
      if (g_valid && g_ready) begin
        xf_g++; xcyc_g = cyc; n_cmp++;
        if (q_g.size() == 0) begin
          n_fail++; $display("FAIL big_word: got r=%h t=%h last=%b, required no transfer", g_r, g_t, g_last);
        end else begin
          eg = q_g.pop_front();
          if (g_r !== eg.r || g_t !== eg.t || g_last !== eg.last) begin
            n_fail++;
            $display("FAIL big_word: got r=%h t=%h last=%b, required r=%h t=%h last=%b", g_r, g_t, g_last, eg.r, eg.t, eg.last);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // 2^16 mod 0xFFF1 = 0x000F and 0x000F^2 = 0x00E1.
  task automatic push_fff1();
    q_a.push_back('{32'h00, 32'h00, 1'b0}); q_a.push_back('{32'h0F, 32'hE1, 1'b1});
    q_b.push_back('{32'h0F, 32'hE1, 1'b0}); q_b.push_back('{32'h00, 32'h00, 1'b1});
  endtask

  task automatic launch_small(input logic [15:0] nv, output int e);
    dcyc_a = -10;
    s_n = nv; s_start = 1'b1; tick(); s_start = 1'b0;
    e = 0;
    while (!a_valid && e < 200) begin tick(); e++; end
  endtask

  task automatic drain_small(output bit ok);
    int i = 0;
    while ((a_busy || b_busy) && i < 100) begin tick(); i++; end
    ok = !(a_busy || b_busy);
  endtask

  task automatic golden(input logic [1023:0] nv, output logic [1023:0] r, output logic [1023:0] t,
                        output logic [31:0] inv_neg);
    logic [1024:0] p1;
    logic [2048:0] p2;
    logic [31:0]   x;
    p1 = '0; p1[1024] = 1'b1;
    p2 = '0; p2[2048] = 1'b1;
    r = 1024'(p1 % {1'b0, nv});
    t = 1024'(p2 % {1025'b0, nv});
    x = nv[31:0];
    repeat (4) x = x * (32'd2 - nv[31:0] * x);
    inv_neg = -x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_start = 1'b0; s_ready = 1'b1; s_n = '0;
    g_start = 1'b0; g_ready = 1'b1; g_n = '0;
    tick(); tick();
    n_cmp++;
    if ({a_busy, a_err, a_n0p_valid, a_valid, a_last, a_done, a_n0p, a_r, a_t} !== 30'b0) begin
      n_fail++; $display("FAIL reset_msw: got %h, required 0", {a_busy, a_err, a_n0p_valid, a_valid, a_last, a_done, a_n0p, a_r, a_t});
    end
    n_cmp++;
    if ({b_busy, b_err, b_n0p_valid, b_valid, b_last, b_done, b_n0p, b_r, b_t} !== 30'b0) begin
      n_fail++; $display("FAIL reset_lsw: got %h, required 0", {b_busy, b_err, b_n0p_valid, b_valid, b_last, b_done, b_n0p, b_r, b_t});
    end
    n_cmp++;
    if ({g_busy, g_err, g_n0p_valid, g_valid, g_last, g_done, g_n0p, g_r, g_t} !== 102'b0) begin
      n_fail++; $display("FAIL reset_big: got %h, required 0", {g_busy, g_err, g_n0p_valid, g_valid, g_last, g_done, g_n0p, g_r, g_t});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic(input string tag);
    int e, xa0, xb0, er0;
    bit ok;
    xa0 = xf_a; xb0 = xf_b; er0 = err_a;
    push_fff1();
    launch_small(16'hFFF1, e);
    n_cmp++;
    if (e !== 34) begin n_fail++; $display("FAIL %s_valid_edge: got %0d, required 34", tag, e); end
    drain_small(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: busy still %b, required 0", tag, a_busy); end
    n_cmp++;
    if (xf_a - xa0 !== 2 || xf_b - xb0 !== 2) begin
      n_fail++; $display("FAIL %s_xfers: got %0d/%0d, required 2/2", tag, xf_a - xa0, xf_b - xb0);
    end
    n_cmp++;
    if (dcyc_a - xcyc_a !== 1) begin n_fail++; $display("FAIL %s_done_delay: got %0d, required 1", tag, dcyc_a - xcyc_a); end
    n_cmp++;
    if ({a_n0p, a_n0p_valid, b_n0p, b_n0p_valid} !== {8'hEF, 1'b1, 8'hEF, 1'b1}) begin
      n_fail++; $display("FAIL %s_n0p: got %h/%b %h/%b, required ef/1", tag, a_n0p, a_n0p_valid, b_n0p, b_n0p_valid);
    end
    n_cmp++;
    if (err_a !== er0 || q_a.size() !== 0 || q_b.size() !== 0) begin
      n_fail++; $display("FAIL %s_leftover: err %0d, queued %0d/%0d, required 0", tag, err_a - er0, q_a.size(), q_b.size());
    end
  endtask

  task automatic test_backpressure();
    int e, xa0;
    bit ok;
    xa0 = xf_a;
    push_fff1();
    s_ready = 1'b0;
    launch_small(16'hFFF1, e);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({a_valid, a_r, a_t, a_last, b_valid, b_r, b_t, b_last} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h0F, 8'hE1, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b r=%h t=%h l=%b, required v=1 r=00 t=00 l=0", i, a_valid, a_r, a_t, a_last);
      end
      if (i < 2) tick();
    end
    s_ready = 1'b1;
    drain_small(ok);
    n_cmp++;
    if (!ok || xf_a - xa0 !== 2) begin n_fail++; $display("FAIL bp_xfers: got %0d, required 2", xf_a - xa0); end
    n_cmp++;
    if (dcyc_a - xcyc_a !== 1) begin n_fail++; $display("FAIL bp_done_delay: got %0d, required 1", dcyc_a - xcyc_a); end
  endtask

  task automatic test_bad_modulus();
    logic [15:0] bad [2];
    int ea0, eb0;
    bit moved;
    bad[0] = 16'h1000; bad[1] = 16'h0001;
    for (int j = 0; j < 2; j++) begin
      ea0 = err_a; eb0 = err_b; moved = 1'b0;
      s_n = bad[j]; s_start = 1'b1; tick(); s_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
        moved = moved | a_busy | a_valid | a_done | b_busy | b_valid | b_done;
        tick();
      end
      n_cmp++;
      if (err_a - ea0 !== 1 || err_b - eb0 !== 1) begin
        n_fail++; $display("FAIL bad_err_%h: got %0d/%0d pulses, required 1/1", bad[j], err_a - ea0, err_b - eb0);
      end
      n_cmp++;
      if (moved !== 1'b0 || a_n0p_valid !== 1'b1) begin
        n_fail++; $display("FAIL bad_idle_%h: got active=%b n0p_valid=%b, required 0/1", bad[j], moved, a_n0p_valid);
      end
    end
  endtask

  task automatic test_busy_start_and_reset();
    int e, xa0;
    bit ok;
    push_fff1();
    xa0 = xf_a;
    s_n = 16'hFFF1; s_start = 1'b1; tick(); s_start = 1'b0;
    repeat (5) tick();
    s_n = 16'hFFF3; s_start = 1'b1; tick(); s_start = 1'b0;
    drain_small(ok);
    n_cmp++;
    if (!ok || xf_a - xa0 !== 2 || a_n0p !== 8'hEF) begin
      n_fail++; $display("FAIL busy_start: got xfers=%0d n0p=%h, required 2/ef", xf_a - xa0, a_n0p);
    end
    xa0 = xf_a;
    s_n = 16'hFFF1; s_start = 1'b1; tick(); s_start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({a_busy, a_n0p_valid, a_valid, a_last, a_done, a_n0p, a_r, a_t, b_busy, b_valid, b_r, b_t} !== 45'b0) begin
      n_fail++; $display("FAIL mid_reset: got busy=%b valid=%b n0p=%h, required 0", a_busy, a_valid, a_n0p);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    n_cmp++;
    if (xf_a !== xa0 || a_busy !== 1'b0 || a_n0p_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_quiet: got xfers=%0d busy=%b, required 0/0", xf_a - xa0, a_busy);
    end
    test_basic("after_reset");
  endtask

  task automatic test_full_size(input logic [1023:0] nv, input bit rand_ready, input string tag);
    logic [1023:0] r, t;
    logic [31:0]   np;
    int e, i, x0;
    golden(nv, r, t, np);
    for (int k = 0; k < 32; k++) q_g.push_back('{r[1023-32*k -: 32], t[1023-32*k -: 32], k == 31});
    x0 = xf_g; dcyc_g = -10; g_ready = 1'b1;
    g_n = nv; g_start = 1'b1; tick(); g_start = 1'b0;
    e = 0;
    while (!g_valid && e < 3000) begin tick(); e++; end
    n_cmp++;
    if (e !== 2050) begin n_fail++; $display("FAIL %s_valid_edge: got %0d, required 2050", tag, e); end
    i = 0;
    while (g_busy && i < 500) begin
      if (rand_ready) g_ready = 1'($urandom_range(0, 1));
      tick(); i++;
    end
    g_ready = 1'b1;
    n_cmp++;
    if (g_busy || xf_g - x0 !== 32 || q_g.size() !== 0) begin
      n_fail++; $display("FAIL %s_xfers: got %0d, queued %0d, required 32/0", tag, xf_g - x0, q_g.size());
    end
    n_cmp++;
    if (g_n0p !== np || g_n0p_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_n0p: got %h/%b, required %h/1", tag, g_n0p, g_n0p_valid, np);
    end
    n_cmp++;
    if (dcyc_g - xcyc_g !== 1) begin n_fail++; $display("FAIL %s_done_delay: got %0d, required 1", tag, dcyc_g - xcyc_g); end
  endtask

  initial begin
    logic [1023:0] nv;
    test_reset();
    test_basic("basic");
    test_backpressure();
    test_bad_modulus();
    test_busy_start_and_reset();
    nv = '0; nv[1023] = 1'b1; nv[0] = 1'b1;
    test_full_size(nv, 1'b0, "big_pow2");
    for (int i = 0; i < 32; i++) nv[32*i +: 32] = $urandom;
    nv[0] = 1'b1; nv[1023] = 1'b1;
    test_full_size(nv, 1'b1, "big_rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_const_stream.md
Name: mont_const_stream

Overview:
- Computes the Montgomery constants for an odd modulus n:
  - r = 2^KEY_W mod n
  - t = 2^(2*KEY_W) mod n
  - n0p = -n^-1 mod 2^WORD_W
- Streams r and t out as WORD_W-bit word pairs under a valid/ready handshake.
- Feeds the Montgomery multiplier datapath of the RSA decryption core.
- Successor to the fixed 1024/32 constant loader: parametrised width, word size and word order, handles backpressure, flags bad moduli, and has a real reset.

Parameters:
- KEY_W, 1024: modulus width in bits. Must be a multiple of WORD_W.
- WORD_W, 32: output word width. Range 2 <= WORD_W <= KEY_W.
- MSW_FIRST, 1: 1 = most significant word streamed first; 0 = least significant word first.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  sampled only in IDLE; latches n and begins computation
- n  in  KEY_W  modulus; sampled on the start edge only
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse when n is rejected
- n0p  out  WORD_W  -n^-1 mod 2^WORD_W
- n0p_valid  out  1  high from LOAD until the next accepted start
- out_r  out  WORD_W  current word of r
- out_t  out  WORD_W  current word of t
- out_valid  out  1  word pair valid
- out_ready  in  1  consumer accepts the word pair
- out_last  out  1  high with the final word pair
- done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, err, n0p_valid, out_valid, out_last, done = 0. n0p, out_r, out_t = 0. Internal registers cleared. Reset mid-operation aborts immediately; no partial output follows reset release.
- States: IDLE, CALC, LOAD, STREAM, FIN.
- IDLE + start=1:
  - If n[0]=0 or n=1: pulse err for 1 cycle, stay IDLE, n0p_valid unchanged.
  - Otherwise: latch n into n_reg, acc=1, n0p_valid=0, cycle counter=0, go to CALC.
- start while busy is ignored.
- CALC, exactly 2*KEY_W cycles, one modular doubling per cycle:
  - acc uses KEY_W+1 bits.
  - acc' = 2*acc; if acc' >= n_reg then acc' -= n_reg.
  - After doubling KEY_W, copy acc to r_reg. After doubling 2*KEY_W, copy acc to t_reg.
- n0p inverse, in parallel during the first WORD_W-1 CALC cycles:
  - inv=1.
  - At step i (1..WORD_W-1), if bit i of (n_reg[WORD_W-1:0]*inv) is 1, set inv += 2^i. Arithmetic is mod 2^WORD_W.
  - n0p = (~inv)+1, registered in LOAD.
- LOAD, 1 cycle: n0p and n0p_valid=1; present the first word pair; go to STREAM.
  - out_valid first rises 2*KEY_W+2 edges after the start edge, counting the start edge as edge 0.
- STREAM: NW = KEY_W/WORD_W word pairs. Word index k runs 0..NW-1.
  - MSW_FIRST=1: word k = bits [KEY_W-1-k*WORD_W -: WORD_W].
  - MSW_FIRST=0: word k = bits [k*WORD_W +: WORD_W].
  - A transfer happens on a rising edge with out_valid & out_ready.
  - While out_ready=0, out_r, out_t and out_last hold stable and out_valid stays 1.
  - Back-to-back transfers run at 1 word pair per cycle. out_last = (k==NW-1).
  - The final transfer moves to FIN and drops out_valid.
- FIN, 1 cycle: done=1, then IDLE. n0p stays valid.
- Word counter is $clog2(NW)+1 bits and never wraps. No word is skipped or repeated.

Test Plan (KEY_W=16, WORD_W=8 unless noted):
- Basic run: n=16'hFFF1, MSW_FIRST=1, out_ready tied 1 -> err=0; out_valid rises at edge 34; pairs (r,t) = (00,00) then (0F,E1); out_last on the 2nd pair; done one cycle later; n0p=8'hEF with n0p_valid=1.
- Word order: same n with MSW_FIRST=0 -> pairs (0F,E1) then (00,00).
- Backpressure: drop out_ready for 3 cycles while the first pair is presented -> first pair held stable with out_valid=1 throughout; exactly 2 transfers total; done follows the last transfer by 1 cycle.
- Bad modulus: n=16'h1000, then n=16'h0001 -> one err pulse each; busy, out_valid and done stay 0; FSM stays IDLE.
- Start while busy / reset mid-run: assert start with a different n during CALC -> ignored, outputs match the first n. Assert rst_n=0 at CALC cycle 10 -> all outputs 0 immediately. A new run after release gives the basic-run results.
- Full size: KEY_W=1024, WORD_W=32, n = 2^1023+1 (random odd n as a second case) -> r, t, n0p match the golden model; 32 transfers; out_valid at edge 2050.
